// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions for the serial encoder/decoder pair.
// Optional macro HAMMING_EXT_PARITY_EN widens the frame to 8 bits (SECDED).
package hamming_pkg;

  localparam int DATA_LEN = 4;
`ifdef HAMMING_EXT_PARITY_EN
  localparam int CODE_LEN = 8;
`else
  localparam int CODE_LEN = 7;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // c[0..6] = positions 1..7: p1 p2 d0 p4 d1 d2 d3
  function automatic logic [6:0] hamming74_encode(
    input logic [3:0] d
  );
    logic [6:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    return c;
  endfunction

endpackage

// File: rtl/hamming74_encode_comb.sv
// Combinational nibble-to-codeword block.
// Ports: i_data nibble in, o_code codeword out (CODE_LEN bits).
// Macro HAMMING_EXT_PARITY_EN appends overall parity as the top bit.
module hamming74_encode_comb
  import hamming_pkg::*;
(
  input  logic [DATA_LEN-1:0] i_data,
  output logic [CODE_LEN-1:0] o_code
);

  logic [6:0] w_c;

  assign w_c = hamming74_encode(i_data);

`ifdef HAMMING_EXT_PARITY_EN
  assign o_code = {^w_c, w_c};
`else
  assign o_code = w_c;
`endif

endmodule

// File: rtl/tt_um_hamming_encoder_74.sv
// Serial Hamming(7,4) transmitter: valid/ready nibble in, LSB-first
// codeword out with frame strobe and end-of-frame done pulse.
// Ports: clk, rst_n (async, low), ena (freeze when low),
//   data_in/data_valid/data_ready handshake,
//   encode_out serial bit, frame_out strobe, done pulse.
// Macro HAMMING_EXT_PARITY_EN selects 8-bit SECDED frames.
module tt_um_hamming_encoder_74
  import hamming_pkg::*;
#(
  parameter int   BIT_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       encode_out,
  output logic       frame_out,
  output logic       done
);

  localparam logic [7:0] LAST_CYC = 8'(BIT_CYCLES - 1);
  localparam logic [2:0] LAST_BIT = 3'(CODE_LEN - 1);

  state_t              r_state;
  logic [CODE_LEN-2:0] r_shift;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_cyc_cnt;
  logic                r_out;
  logic                r_frame;
  logic                r_done;

  logic [CODE_LEN-1:0] w_code;
  logic                w_cyc_end;
  logic                w_last_slot;
  logic                w_hs;

  hamming74_encode_comb u_enc (
    .i_data (data_in),
    .o_code (w_code)
  );

  assign w_cyc_end   = (r_cyc_cnt == LAST_CYC);
  assign w_last_slot = (r_state == SHIFT) && w_cyc_end
                     && (r_bit_idx == LAST_BIT);

  // Ready in idle, and in the final slot so frames can abut.
  assign data_ready = rst_n & ena
                    & ((r_state == IDLE) | w_last_slot);
  assign w_hs       = data_valid & data_ready;

  assign encode_out = r_out;
  assign frame_out  = r_frame;
  assign done       = r_done & ena;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_cyc_cnt <= '0;
      r_out     <= IDLE_LEVEL;
      r_frame   <= 1'b0;
      r_done    <= 1'b0;
    end else if (!ena) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_last_slot;
      if (w_hs) begin
        // c0 goes straight to the pin; the rest waits in r_shift.
        r_shift   <= w_code[CODE_LEN-1:1];
        r_out     <= w_code[0];
        r_frame   <= 1'b1;
        r_bit_idx <= '0;
        r_cyc_cnt <= '0;
        r_state   <= SHIFT;
      end else if (r_state == SHIFT) begin
        if (!w_cyc_end) begin
          r_cyc_cnt <= r_cyc_cnt + 8'd1;
        end else if (r_bit_idx != LAST_BIT) begin
          r_cyc_cnt <= '0;
          r_bit_idx <= r_bit_idx + 3'd1;
          r_out     <= r_shift[0];
          r_shift   <= r_shift >> 1;
        end else begin
          r_cyc_cnt <= '0;
          r_bit_idx <= '0;
          r_out     <= IDLE_LEVEL;
          r_frame   <= 1'b0;
          r_state   <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_um_hamming_encoder_74.sv
// Scoreboard bench for the serial Hamming(7,4) encoder.
// Expected bits queued at handshake; a negedge monitor checks them.
module tb_tt_um_hamming_encoder_74;
  import hamming_pkg::*;

  localparam int BC = 3;
  localparam int CL = CODE_LEN;

  localparam logic [6:0] TAB [16] = '{
    7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
    7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [3:0] data_in = 4'h0;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       encode_out;
  logic       frame_out;
  logic       done;

  int total = 0;
  int bad = 0;

  bit         exp_q[$];
  logic [3:0] nib_q[$];
  int         cnt = 0;
  logic       exp_done = 1'b0;
  logic [7:0] rx = '0;
  bit         exp_b;
  logic [3:0] exp_n;
  bit         stream_mon = 1'b0;
  int         drops = 0;

  tt_um_hamming_encoder_74 #(
    .BIT_CYCLES (BC),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .encode_out (encode_out),
    .frame_out  (frame_out),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] code_of(input logic [3:0] n);
    logic [6:0] t;
    t = TAB[n];
    return {^t, t};
  endfunction

  function automatic logic [3:0] dec(input logic [6:0] c);
    logic [6:0] x;
    logic [2:0] s;
    x = c;
    s[0] = x[0] ^ x[2] ^ x[4] ^ x[6];
    s[1] = x[1] ^ x[2] ^ x[5] ^ x[6];
    s[2] = x[3] ^ x[4] ^ x[5] ^ x[6];
    if (s != 3'd0) x[s - 3'd1] = ~x[s - 3'd1];
    return {x[6], x[5], x[4], x[2]};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      nib_q.delete();
      cnt = 0;
      exp_done = 1'b0;
    end else begin
      if (exp_done || done) begin
        chk("done_pulse", 32'(done), 32'(exp_done));
        if (exp_done && !frame_out)
          chk("idle_level", 32'(encode_out), 32'(0));
        exp_done = 1'b0;
      end
      if (frame_out && ena) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bit", 32'(1), 32'(0));
        end else begin
          exp_b = exp_q.pop_front();
          chk("serial_bit", 32'(encode_out), 32'(exp_b));
        end
        rx[cnt / BC] = encode_out;
        cnt++;
        if (cnt == CL * BC) begin
          cnt = 0;
          exp_done = 1'b1;
          if (nib_q.size() > 0) begin
            exp_n = nib_q.pop_front();
            for (int k = 0; k < 7; k++)
              chk("decode_flip",
                  32'(dec(rx[6:0] ^ (7'(1) << k))), 32'(exp_n));
          end
        end
      end
    end
  end

  always @(negedge clk)
    if (stream_mon && !frame_out) drops++;

  task automatic send(input logic [3:0] n, input bit keep);
    int w;
    logic [7:0] c;
    w = 0;
    data_in = n;
    data_valid = 1'b1;
    @(negedge clk);
    while (!data_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!data_ready) begin
      chk("accept_timeout", 32'(0), 32'(1));
      data_valid = 1'b0;
      return;
    end
    c = code_of(n);
    for (int b = 0; b < CL; b++)
      for (int r = 0; r < BC; r++)
        exp_q.push_back(c[b]);
    nib_q.push_back(n);
    @(posedge clk);
    #1;
    data_in = ~n;
    data_valid = keep;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((frame_out || exp_q.size() != 0) && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("idle_timeout", 32'(frame_out), 32'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic so;
    logic sf;
    int frz;
    ena = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(encode_out), 32'(0));
    chk("rst_frame", 32'(frame_out), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_ready", 32'(data_ready), 32'(0));
    rst_n = 1'b1;
    #1;
    chk("ready_idle", 32'(data_ready), 32'(1));

    send(4'hB, 1'b0);
    wait_idle();
    send(4'h1, 1'b0);
    wait_idle();

    send(4'h0, 1'b1);
    stream_mon = 1'b1;
    send(4'hF, 1'b0);
    repeat (CL * BC - 1) @(posedge clk);
    #1;
    stream_mon = 1'b0;
    chk("stream_gap", 32'(drops), 32'(0));
    wait_idle();

    send(4'hB, 1'b0);
    repeat (3 * BC) @(posedge clk);
    #1;
    ena = 1'b0;
    #1;
    so = encode_out;
    sf = frame_out;
    frz = 0;
    repeat (5) begin
      @(negedge clk);
      if (encode_out !== so || frame_out !== sf
          || data_ready !== 1'b0 || done !== 1'b0)
        frz++;
    end
    chk("ena_freeze", 32'(frz), 32'(0));
    chk("frozen_frame", 32'(sf), 32'(1));
    chk("frozen_bit3", 32'(so), 32'(0));
    @(posedge clk);
    #1;
    ena = 1'b1;
    wait_idle();

    send(4'h6, 1'b0);
    repeat (4 * BC) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out", 32'(encode_out), 32'(0));
    chk("abort_frame", 32'(frame_out), 32'(0));
    chk("abort_ready", 32'(data_ready), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(4'h9, 1'b0);
    wait_idle();

    for (int n = 0; n < 16; n++)
      send(4'(n), n != 15);
    wait_idle();

    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    total++;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
